// File: rtl/ps2_multi_player_dir_ctrl_pkg.sv
// lightbike_input_pkg: direction encoding, PS/2 prefixes, decoder states and reset tables
// shared by the multi-player PS/2 direction controller.
package lightbike_input_pkg;
    typedef logic [1:0] dir_t;
    localparam dir_t DIR_UP = 2'd0;
    localparam dir_t DIR_RIGHT = 2'd1;
    localparam dir_t DIR_DOWN = 2'd2;
    localparam dir_t DIR_LEFT = 2'd3;
    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT = 8'hE0;
    typedef enum logic [1:0] {ST_IDLE, ST_EXT, ST_BRK} dec_state_t;
    localparam dir_t INIT_DIR [4] = '{DIR_RIGHT, DIR_LEFT, DIR_DOWN, DIR_UP};
    // Indexed [player][dir] with dir order up, right, down, left
    localparam logic [8:0] DEFAULT_MAP [4][4] = '{
        '{9'h01D, 9'h023, 9'h01B, 9'h01C},
        '{9'h02C, 9'h033, 9'h034, 9'h02B},
        '{9'h043, 9'h04B, 9'h042, 9'h03B},
        '{9'h075, 9'h074, 9'h073, 9'h06B}
    };
    function automatic dir_t reverse_dir(dir_t d);
        return d ^ 2'd2;
    endfunction
    function automatic logic [8:0] default_code(int p, int d);
        return p < 4 ? DEFAULT_MAP[p[1:0]][d[1:0]] : 9'h000;
    endfunction
endpackage

// File: rtl/ps2_multi_player_dir_ctrl_if.sv
// ps2_multi_player_dir_ctrl_if: key, game-control, keymap-write and direction-output bundle.
interface ps2_multi_player_dir_ctrl_if #(parameter int NUM_PLAYERS = 4);
    logic key_valid;
    logic [7:0] key_data;
    logic game_en;
    logic tick;
    logic [NUM_PLAYERS-1:0] crash;
    logic map_we;
    logic [2:0] map_player;
    logic [1:0] map_dir;
    logic [8:0] map_code;
    logic clr_ovf;
    logic [2*NUM_PLAYERS-1:0] dir_out;
    logic [NUM_PLAYERS-1:0] dir_changed;
    logic [NUM_PLAYERS-1:0] q_overflow;
    modport master (
        output key_valid, key_data, game_en, tick, crash, map_we, map_player, map_dir, map_code, clr_ovf,
        input dir_out, dir_changed, q_overflow
    );
    modport slave (
        input key_valid, key_data, game_en, tick, crash, map_we, map_player, map_dir, map_code, clr_ovf,
        output dir_out, dir_changed, q_overflow
    );
endinterface

// File: rtl/ps2_multi_player_dir_ctrl_dir_queue.sv
// dir_queue: DEPTH-entry synchronous FIFO of turn requests; flush empties it, flush wins over push.
module dir_queue
    import lightbike_input_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic push,
    input  logic pop,
    input  logic flush,
    input  dir_t din,
    output dir_t dout,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);
    logic [AW:0] wp, rp;
    dir_t mem [DEPTH];
    assign empty = wp == rp;
    assign full = wp[AW] != rp[AW] && wp[AW-1:0] == rp[AW-1:0];
    assign dout = mem[rp[AW-1:0]];
    always_ff @(posedge clock)
        if (reset || flush) begin
            wp <= '0;
            rp <= '0;
        end else begin
            wp <= push ? wp + (AW+1)'(1) : wp;
            rp <= pop ? rp + (AW+1)'(1) : rp;
        end
    always_ff @(posedge clock)
        if (push) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/ps2_multi_player_dir_ctrl.sv
// ps2_multi_player_dir_ctrl: PS/2 scancodes -> per-bike turn queues -> tick-applied directions.
// Optional TYPEMATIC_FILTER_EN suppresses auto-repeated makes until the key is released.
module ps2_multi_player_dir_ctrl
    import lightbike_input_pkg::*;
#(
    parameter int NUM_PLAYERS = 4,
    parameter int QUEUE_DEPTH = 2
) (
    input logic clock,
    input logic reset,
    ps2_multi_player_dir_ctrl_if.slave bus
);
    dec_state_t state, state_nx;
    logic make, make_ok;
    logic [8:0] code;
    logic [8:0] keymap [NUM_PLAYERS][4];
    logic [NUM_PLAYERS-1:0] hit, push_q;
    dir_t hit_dir, push_dir_q;

    always_ff @(posedge clock) state <= reset ? ST_IDLE : state_nx;

    always_comb begin
        state_nx = state;
        make = 1'b0;
        code = {state == ST_EXT, bus.key_data};
        if (bus.key_valid) begin
            if (state == ST_BRK) state_nx = ST_IDLE;
            else if (bus.key_data == PS2_BREAK) state_nx = ST_BRK;
            else if (bus.key_data == PS2_EXT && state == ST_IDLE) state_nx = ST_EXT;
            else begin
                state_nx = ST_IDLE;
                make = 1'b1;
            end
        end
    end

`ifdef TYPEMATIC_FILTER_EN
    logic [8:0] last_make;
    always_ff @(posedge clock)
        if (reset || (bus.key_valid && state == ST_BRK)) last_make <= '0;
        else if (make) last_make <= code;
    assign make_ok = make && code != last_make;
`else
    assign make_ok = make;
`endif

    // Scan high to low so the lowest player, then lowest direction, is the last writer
    always_comb begin
        hit = '0;
        hit_dir = DIR_UP;
        for (int p = NUM_PLAYERS - 1; p >= 0; p--)
            for (int d = 3; d >= 0; d--)
                if (make_ok && code != 9'h000 && code == keymap[p][d]) begin
                    hit = '0;
                    hit[p] = 1'b1;
                    hit_dir = dir_t'(d);
                end
    end

    always_ff @(posedge clock)
        if (reset) begin
            push_q <= '0;
            push_dir_q <= DIR_UP;
        end else begin
            push_q <= hit;
            push_dir_q <= hit_dir;
        end

    always_ff @(posedge clock)
        for (int p = 0; p < NUM_PLAYERS; p++)
            for (int d = 0; d < 4; d++)
                if (reset) keymap[p][d] <= default_code(p, d);
                else if (bus.map_we && int'(bus.map_player) == p && bus.map_dir == d[1:0]) keymap[p][d] <= bus.map_code;

    for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_player
        dir_t dir, head;
        logic full, empty, flush, push, pop, apply, chg, ovf;
        // A stopped game or a crashed bike keeps its queue empty and ignores new requests
        assign flush = ~bus.game_en | bus.crash[g];
        assign push = push_q[g] & ~flush;
        assign pop = bus.tick & ~flush & ~empty;
        assign apply = pop && head != dir && head != reverse_dir(dir);
        dir_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
            .clock(clock),
            .reset(reset),
            .push(push & (~full | pop)),
            .pop(pop),
            .flush(flush),
            .din(push_dir_q),
            .dout(head),
            .full(full),
            .empty(empty)
        );
        always_ff @(posedge clock)
            if (reset) begin
                dir <= INIT_DIR[g % 4];
                chg <= 1'b0;
                ovf <= 1'b0;
            end else begin
                dir <= apply ? head : dir;
                chg <= apply;
                ovf <= (push & full & ~pop) | (ovf & ~bus.clr_ovf);
            end
        assign bus.dir_out[2*g +: 2] = dir;
        assign bus.dir_changed[g] = chg;
        assign bus.q_overflow[g] = ovf;
    end
endmodule

// File: tb/tb_ps2_multi_player_dir_ctrl.sv
// tb_ps2_multi_player_dir_ctrl: directed vector table plus randomized traffic against a queue-level model.
module tb_ps2_multi_player_dir_ctrl;
    localparam int NP = 4;
    localparam int QD = 2;
`ifdef TYPEMATIC_FILTER_EN
    localparam bit FILTER = 1'b1;
`else
    localparam bit FILTER = 1'b0;
`endif
    localparam logic [3:0] OV6 = FILTER ? 4'h0 : 4'h1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ps2_multi_player_dir_ctrl_if #(.NUM_PLAYERS(NP)) bus();
    ps2_multi_player_dir_ctrl #(.NUM_PLAYERS(NP), .QUEUE_DEPTH(QD)) dut (
        .clock(clk),
        .reset(rst),
        .bus(bus)
    );

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct {
        logic r, kv, ge, tk, clr, mwe;
        logic [7:0] kd;
        logic [NP-1:0] cr;
        logic [2:0] mp;
        logic [1:0] md;
        logic [8:0] mc;
        logic [2*NP-1:0] ed;
        logic [NP-1:0] ec, eo;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic r, kv, input logic [7:0] kd, input logic ge, tk, input logic [NP-1:0] cr,
                       input logic clr, input logic [2*NP-1:0] ed, input logic [NP-1:0] ec, eo);
        vec_t v;
        v = '{default: '0};
        v.r = r; v.kv = kv; v.kd = kd; v.ge = ge; v.tk = tk; v.cr = cr; v.clr = clr;
        v.ed = ed; v.ec = ec; v.eo = eo;
        tbl.push_back(v);
    endtask
    task automatic rst_v();
        add(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 4'h0, 1'b0, 8'h2D, 4'h0, 4'h0);
    endtask
    task automatic key_v(input logic [7:0] kd, input logic [7:0] ed, input logic [3:0] ec, eo);
        add(1'b0, 1'b1, kd, 1'b1, 1'b0, 4'h0, 1'b0, ed, ec, eo);
    endtask
    task automatic idle_v(input logic [7:0] ed, input logic [3:0] ec, eo);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 4'h0, 1'b0, ed, ec, eo);
    endtask
    task automatic tick_v(input logic [7:0] ed, input logic [3:0] ec, eo);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 4'h0, 1'b0, ed, ec, eo);
    endtask
    task automatic map_v(input logic kv, input logic [7:0] kd, input logic [2:0] mp, input logic [1:0] md,
                         input logic [8:0] mc, input logic [7:0] ed, input logic [3:0] ec, eo);
        add(1'b0, kv, kd, 1'b1, 1'b0, 4'h0, 1'b0, ed, ec, eo);
        tbl[tbl.size()-1].mwe = 1'b1;
        tbl[tbl.size()-1].mp = mp;
        tbl[tbl.size()-1].md = md;
        tbl[tbl.size()-1].mc = mc;
    endtask

    task automatic drive(input vec_t v);
        rst = v.r; bus.key_valid = v.kv; bus.key_data = v.kd; bus.game_en = v.ge; bus.tick = v.tk;
        bus.crash = v.cr; bus.clr_ovf = v.clr; bus.map_we = v.mwe; bus.map_player = v.mp;
        bus.map_dir = v.md; bus.map_code = v.mc;
    endtask

    // Reference model: keymap, per-player request lists, prefix flags
    logic [7:0] spec_keys [4][4] = '{  // left, right, up, down per player
        '{8'h1C, 8'h23, 8'h1D, 8'h1B}, '{8'h2B, 8'h33, 8'h2C, 8'h34},
        '{8'h3B, 8'h4B, 8'h43, 8'h42}, '{8'h6B, 8'h74, 8'h75, 8'h73}};
    int init_dir [4] = '{1, 3, 2, 0};
    int mq [NP][$];
    int mdir [NP];
    logic [NP-1:0] mchg, movf;
    logic [8:0] mmap [NP][4];
    logic pend, m_ext, m_brk;
    int pend_p, pend_d, m_h, m_mp;
    logic [8:0] m_code, m_last;

    always @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < NP; p++) begin
                mq[p].delete();
                mdir[p] = init_dir[p % 4];
                mmap[p][3] = p < 4 ? {1'b0, spec_keys[p][0]} : 9'h000;
                mmap[p][1] = p < 4 ? {1'b0, spec_keys[p][1]} : 9'h000;
                mmap[p][0] = p < 4 ? {1'b0, spec_keys[p][2]} : 9'h000;
                mmap[p][2] = p < 4 ? {1'b0, spec_keys[p][3]} : 9'h000;
            end
            mchg = '0; movf = '0; pend = 1'b0; m_ext = 1'b0; m_brk = 1'b0; m_last = '0;
        end else begin
            for (int p = 0; p < NP; p++) begin
                mchg[p] = 1'b0;
                if (bus.tick && bus.game_en && !bus.crash[p] && mq[p].size() > 0) begin
                    m_h = mq[p].pop_front();
                    if (m_h != mdir[p] && m_h != (mdir[p] ^ 2)) begin
                        mdir[p] = m_h;
                        mchg[p] = 1'b1;
                    end
                end
                if (bus.clr_ovf) movf[p] = 1'b0;
                if (pend && pend_p == p && bus.game_en && !bus.crash[p]) begin
                    if (mq[p].size() < QD) mq[p].push_back(pend_d);
                    else movf[p] = 1'b1;
                end
                if (!bus.game_en || bus.crash[p]) mq[p].delete();
            end
            pend = 1'b0;
            if (bus.key_valid) begin
                if (m_brk) begin
                    m_brk = 1'b0;
                    m_last = '0;
                end else if (bus.key_data == 8'hF0) begin
                    m_brk = 1'b1;
                    m_ext = 1'b0;
                end else if (bus.key_data == 8'hE0 && !m_ext) m_ext = 1'b1;
                else begin
                    m_code = {m_ext, bus.key_data};
                    m_ext = 1'b0;
                    if (!(FILTER && m_code == m_last))
                        for (int p = 0; p < NP; p++)
                            for (int d = 0; d < 4; d++)
                                if (!pend && m_code != 9'h000 && mmap[p][d] == m_code) begin
                                    pend = 1'b1; pend_p = p; pend_d = d;
                                end
                    m_last = m_code;
                end
            end
            m_mp = int'(bus.map_player);
            if (bus.map_we && m_mp < NP) mmap[m_mp][bus.map_dir] = bus.map_code;
        end
    end

    logic [7:0] pool [17] = '{8'h1D, 8'h23, 8'h1B, 8'h1C, 8'h2C, 8'h33, 8'h34, 8'h2B, 8'h43,
                              8'h4B, 8'h42, 8'h3B, 8'h75, 8'h74, 8'h73, 8'h6B, 8'h00};

    initial begin
        logic [2*NP-1:0] edv;
        logic [NP-1:0] crv;
        vec_t v;
        // empty-queue tick, then apply
        rst_v(); key_v(8'h1D, 8'h2D, 4'h0, 4'h0); idle_v(8'h2D, 4'h0, 4'h0);
        tick_v(8'h2C, 4'h1, 4'h0); idle_v(8'h2C, 4'h0, 4'h0);
        // reversal rejected then up accepted
        rst_v(); key_v(8'h1C, 8'h2D, 4'h0, 4'h0); key_v(8'h1D, 8'h2D, 4'h0, 4'h0);
        tick_v(8'h2D, 4'h0, 4'h0); tick_v(8'h2C, 4'h1, 4'h0); idle_v(8'h2C, 4'h0, 4'h0);
        // overflow, clear, drain
        rst_v(); key_v(8'h2C, 8'h2D, 4'h0, 4'h0); key_v(8'h33, 8'h2D, 4'h0, 4'h0);
        key_v(8'h34, 8'h2D, 4'h0, 4'h0); idle_v(8'h2D, 4'h0, 4'h2);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 4'h0, 1'b1, 8'h2D, 4'h0, 4'h0);
        tick_v(8'h21, 4'h2, 4'h0); tick_v(8'h25, 4'h2, 4'h0); idle_v(8'h25, 4'h0, 4'h0);
        // full + push + pop: no overflow
        rst_v(); key_v(8'h2C, 8'h2D, 4'h0, 4'h0); key_v(8'h33, 8'h2D, 4'h0, 4'h0);
        key_v(8'h34, 8'h2D, 4'h0, 4'h0); tick_v(8'h21, 4'h2, 4'h0);
        tick_v(8'h25, 4'h2, 4'h0); tick_v(8'h29, 4'h2, 4'h0);
        // same-cycle push and tick on an empty queue is not bypassed
        rst_v(); key_v(8'h1D, 8'h2D, 4'h0, 4'h0); tick_v(8'h2D, 4'h0, 4'h0); tick_v(8'h2C, 4'h1, 4'h0);
        // extended code and keymap write, then release ignored
        rst_v(); key_v(8'hE0, 8'h2D, 4'h0, 4'h0); key_v(8'h75, 8'h2D, 4'h0, 4'h0);
        idle_v(8'h2D, 4'h0, 4'h0); tick_v(8'h2D, 4'h0, 4'h0);
        map_v(1'b0, 8'h00, 3'd3, 2'd1, 9'h175, 8'h2D, 4'h0, 4'h0);
        key_v(8'hE0, 8'h2D, 4'h0, 4'h0); key_v(8'h75, 8'h2D, 4'h0, 4'h0);
        idle_v(8'h2D, 4'h0, 4'h0); tick_v(8'h6D, 4'h8, 4'h0); idle_v(8'h6D, 4'h0, 4'h0);
        key_v(8'hF0, 8'h6D, 4'h0, 4'h0); key_v(8'h75, 8'h6D, 4'h0, 4'h0);
        idle_v(8'h6D, 4'h0, 4'h0); tick_v(8'h6D, 4'h0, 4'h0);
        // make in the same cycle as a map write uses the old map
        rst_v(); map_v(1'b1, 8'h1D, 3'd0, 2'd0, 9'h01B, 8'h2D, 4'h0, 4'h0);
        idle_v(8'h2D, 4'h0, 4'h0); tick_v(8'h2C, 4'h1, 4'h0);
        key_v(8'h1D, 8'h2C, 4'h0, 4'h0); idle_v(8'h2C, 4'h0, 4'h0); tick_v(8'h2C, 4'h0, 4'h0);
        // crash freezes a bike; game_en low flushes the others
        rst_v();
        add(1'b0, 1'b1, 8'h43, 1'b1, 1'b0, 4'h4, 1'b0, 8'h2D, 4'h0, 4'h0);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 4'h4, 1'b0, 8'h2D, 4'h0, 4'h0);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 4'h4, 1'b0, 8'h2D, 4'h0, 4'h0);
        add(1'b0, 1'b1, 8'h1D, 1'b1, 1'b0, 4'h4, 1'b0, 8'h2D, 4'h0, 4'h0);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 4'h4, 1'b0, 8'h2D, 4'h0, 4'h0);
        add(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'h4, 1'b0, 8'h2D, 4'h0, 4'h0);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 4'h4, 1'b0, 8'h2D, 4'h0, 4'h0);
        // auto-repeat
        rst_v(); key_v(8'h1D, 8'h2D, 4'h0, 4'h0); key_v(8'h1D, 8'h2D, 4'h0, 4'h0);
        key_v(8'h1D, 8'h2D, 4'h0, 4'h0); idle_v(8'h2D, 4'h0, OV6);
        tick_v(8'h2C, 4'h1, OV6); tick_v(8'h2C, 4'h0, OV6);
        rst_v(); key_v(8'h1D, 8'h2D, 4'h0, 4'h0); key_v(8'hF0, 8'h2D, 4'h0, 4'h0);
        key_v(8'h1D, 8'h2D, 4'h0, 4'h0); key_v(8'h1D, 8'h2D, 4'h0, 4'h0);
        idle_v(8'h2D, 4'h0, 4'h0); tick_v(8'h2C, 4'h1, 4'h0); tick_v(8'h2C, 4'h0, 4'h0);

        foreach (tbl[i]) begin
            drive(tbl[i]);
            @(posedge clk);
            @(negedge clk);
            check($sformatf("vec%0d_dir", i), 32'(bus.dir_out), 32'(tbl[i].ed));
            check($sformatf("vec%0d_chg", i), 32'(bus.dir_changed), 32'(tbl[i].ec));
            check($sformatf("vec%0d_ovf", i), 32'(bus.q_overflow), 32'(tbl[i].eo));
        end

        crv = '0;
        for (int i = 0; i < 3000; i++) begin
            v = '{default: '0};
            v.r = i == 0 || $urandom_range(0, 299) == 0;
            if (v.r) crv = '0;
            else if ($urandom_range(0, 199) == 0) crv[$urandom_range(0, NP-1)] = 1'b1;
            v.cr = crv;
            v.kv = $urandom_range(0, 2) == 0;
            case ($urandom_range(0, 9))
                0: v.kd = 8'hE0;
                1: v.kd = 8'hF0;
                2: v.kd = 8'($urandom);
                default: v.kd = pool[$urandom_range(0, 16)];
            endcase
            v.ge = $urandom_range(0, 49) != 0;
            v.tk = $urandom_range(0, 3) == 0;
            v.clr = $urandom_range(0, 19) == 0;
            v.mwe = $urandom_range(0, 39) == 0;
            v.mp = 3'($urandom_range(0, 7));
            v.md = 2'($urandom_range(0, 3));
            v.mc = {1'($urandom_range(0, 1)), pool[$urandom_range(0, 16)]};
            drive(v);
            @(posedge clk);
            @(negedge clk);
            for (int p = 0; p < NP; p++) edv[2*p +: 2] = 2'(mdir[p]);
            check($sformatf("rnd%0d_dir", i), 32'(bus.dir_out), 32'(edv));
            check($sformatf("rnd%0d_chg", i), 32'(bus.dir_changed), 32'(mchg));
            check($sformatf("rnd%0d_ovf", i), 32'(bus.q_overflow), 32'(movf));
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
